padding_window_reader: RTL and testbench

- Consumer side of the padded three-row buffer. Takes the three stored padded rows (R/G/B, row0..row2) and the row rotation.
- Snapshots the rows on start, then slides a 3x3 window across all output columns of one image row.
- Presents one R/G/B 3x3 window per column to the conv datapath over a valid/ready handshake.

---
 rtl/padding_window_reader_if.sv | 20 ++
 rtl/padding_window_reader.sv | 141 ++++++++++++++
 tb/tb_padding_window_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/padding_window_reader_if.sv
// padding_window_reader_if: window stream from the padded-row reader to the conv datapath
//   win_valid/win_ready : handshake
//   R_win/G_win/B_win   : 3x3 window per colour, pixel k=r*3+c at [k*DW +: DW]
//   col                 : output column of the current window
//   last                : window at the final column of the row
interface padding_window_reader_if #(
    parameter int IMG_W = 416,
    parameter int DW    = 8
);
    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] R_win;
    logic [9*DW-1:0] G_win;
    logic [9*DW-1:0] B_win;
    logic [8:0]      col;
    logic            last;

    modport master (output win_valid, R_win, G_win, B_win, col, last, input win_ready);
    modport slave  (input win_valid, R_win, G_win, B_win, col, last, output win_ready);
endinterface

// File: rtl/padding_window_reader.sv
// padding_window_reader: snapshots three padded RGB rows and streams one 3x3 window per output column
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin one row pass (sampled only in IDLE)
//   top_row             : buffer row forming window row 0 (3 treated as 0)
//   {R,G,B}_row{0,1,2}  : padded rows, pixel p at [p*DW +: DW]
//   win                 : window stream (master side of padding_window_reader_if)
//   busy                : high while loading or streaming
//   done                : one-cycle pulse after the last window is accepted
//   stall_cnt           : saturating count of stalled valid cycles (only with PADDING_WINDOW_STALL_CNT_EN)
module padding_window_reader #(
    parameter int IMG_W = 416,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              top_row,
    input  logic [(IMG_W+2)*DW-1:0] R_row0,
    input  logic [(IMG_W+2)*DW-1:0] G_row0,
    input  logic [(IMG_W+2)*DW-1:0] B_row0,
    input  logic [(IMG_W+2)*DW-1:0] R_row1,
    input  logic [(IMG_W+2)*DW-1:0] G_row1,
    input  logic [(IMG_W+2)*DW-1:0] B_row1,
    input  logic [(IMG_W+2)*DW-1:0] R_row2,
    input  logic [(IMG_W+2)*DW-1:0] G_row2,
    input  logic [(IMG_W+2)*DW-1:0] B_row2,
    padding_window_reader_if.master win,
    output logic                    busy,
    output logic                    done
`ifdef PADDING_WINDOW_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    localparam int RW = (IMG_W + 2) * DW;
    localparam logic [8:0] LAST_COL = 9'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;

    logic [RW-1:0] rs_t, rs_m, rs_b, gs_t, gs_m, gs_b, bs_t, bs_m, bs_b;
    logic [8:0]    col_nx;
    logic          fire;

    // Rotates (a,b,c) so that index s lands first; s==3 falls through to a.
    function automatic logic [RW-1:0] pick(input logic [RW-1:0] a, b, c, input logic [1:0] s);
        return s == 2'd1 ? b : s == 2'd2 ? c : a;
    endfunction

    function automatic logic [9*DW-1:0] win3(input logic [RW-1:0] t, m, b, input logic [8:0] c);
        logic [RW-1:0] rows [3];
        logic [9*DW-1:0] w;
        rows[0] = t;
        rows[1] = m;
        rows[2] = b;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[(r*3+k)*DW +: DW] = rows[r][(int'(c)+k)*DW +: DW];
        return w;
    endfunction

    wire [RW-1:0] ri_t = pick(R_row0, R_row1, R_row2, top_row);
    wire [RW-1:0] ri_m = pick(R_row1, R_row2, R_row0, top_row);
    wire [RW-1:0] ri_b = pick(R_row2, R_row0, R_row1, top_row);
    wire [RW-1:0] gi_t = pick(G_row0, G_row1, G_row2, top_row);
    wire [RW-1:0] gi_m = pick(G_row1, G_row2, G_row0, top_row);
    wire [RW-1:0] gi_b = pick(G_row2, G_row0, G_row1, top_row);
    wire [RW-1:0] bi_t = pick(B_row0, B_row1, B_row2, top_row);
    wire [RW-1:0] bi_m = pick(B_row1, B_row2, B_row0, top_row);
    wire [RW-1:0] bi_b = pick(B_row2, B_row0, B_row1, top_row);

    assign fire   = win.win_valid && win.win_ready;
    assign col_nx = win.col + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            win.win_valid <= 1'b0;
            win.last      <= 1'b0;
            win.col       <= '0;
            win.R_win     <= '0;
            win.G_win     <= '0;
            win.B_win     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            {rs_t, rs_m, rs_b, gs_t, gs_m, gs_b, bs_t, bs_m, bs_b} <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    // The first window comes straight from the live rows so it is ready
                    // in the same edge that captures the snapshot.
                    {rs_t, rs_m, rs_b} <= {ri_t, ri_m, ri_b};
                    {gs_t, gs_m, gs_b} <= {gi_t, gi_m, gi_b};
                    {bs_t, bs_m, bs_b} <= {bi_t, bi_m, bi_b};
                    win.R_win     <= win3(ri_t, ri_m, ri_b, 9'd0);
                    win.G_win     <= win3(gi_t, gi_m, gi_b, 9'd0);
                    win.B_win     <= win3(bi_t, bi_m, bi_b, 9'd0);
                    win.col       <= '0;
                    win.last      <= LAST_COL == 9'd0;
                    win.win_valid <= 1'b1;
                    state         <= RUN;
                end
                RUN: if (fire) begin
                    if (win.last) begin
                        win.win_valid <= 1'b0;
                        win.last      <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        win.col   <= col_nx;
                        win.last  <= col_nx == LAST_COL;
                        win.R_win <= win3(rs_t, rs_m, rs_b, col_nx);
                        win.G_win <= win3(gs_t, gs_m, gs_b, col_nx);
                        win.B_win <= win3(bs_t, bs_m, bs_b, col_nx);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    win.col <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PADDING_WINDOW_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || state == LOAD)
            stall_cnt <= '0;
        else if (win.win_valid && !win.win_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_padding_window_reader.sv
// tb_padding_window_reader: directed self-checking bench for padding_window_reader (IMG_W=4, DW=8)
module tb_padding_window_reader;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int RW = (W + 2) * D;
    localparam logic [71:0] FIRST_T0 = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] FIRST_T1 = 72'h02_01_00_22_21_20_12_11_10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    top_row = 2'd0;
    logic [RW-1:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic          busy, done;
`ifdef PADDING_WINDOW_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif
    int errs = 0;
    int n = 0;

    padding_window_reader_if #(.IMG_W(W), .DW(D)) w();

    padding_window_reader #(.IMG_W(W), .DW(D)) dut (
        .clk(clk), .reset(reset), .start(start), .top_row(top_row),
        .R_row0(r0), .G_row0(g0), .B_row0(b0),
        .R_row1(r1), .G_row1(g1), .B_row1(b1),
        .R_row2(r2), .G_row2(g2), .B_row2(b2),
        .win(w), .busy(busy), .done(done)
`ifdef PADDING_WINDOW_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel (r,c) of the window at column col = row base + col + c.
    function automatic logic [71:0] ew(input int t, input int m, input int b, input int col);
        logic [71:0] e;
        int base [3];
        base[0] = t;
        base[1] = m;
        base[2] = b;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                e[(r*3+k)*8 +: 8] = 8'(base[r] + col + k);
        return e;
    endfunction

    task automatic load_rows(input bit ff);
        for (int p = 0; p < W + 2; p++) begin
            r0[p*8 +: 8] = ff ? 8'hFF : 8'(p);
            r1[p*8 +: 8] = ff ? 8'hFF : 8'(16 + p);
            r2[p*8 +: 8] = ff ? 8'hFF : 8'(32 + p);
            g0[p*8 +: 8] = ff ? 8'hFF : 8'(64 + p);
            g1[p*8 +: 8] = ff ? 8'hFF : 8'(80 + p);
            g2[p*8 +: 8] = ff ? 8'hFF : 8'(96 + p);
            b0[p*8 +: 8] = ff ? 8'hFF : 8'(128 + p);
            b1[p*8 +: 8] = ff ? 8'hFF : 8'(144 + p);
            b2[p*8 +: 8] = ff ? 8'hFF : 8'(160 + p);
        end
    endtask

    // Full pass under continuous ready; t/m/b are the R bases of the window rows.
    task automatic pass(input int t, input int m, input int b, input bit isolate, input logic [71:0] first);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("load_valid", 72'(w.win_valid), 72'd0);
        chk("load_busy", 72'(busy), 72'd1);
        tick;
        if (isolate) load_rows(1'b1);
        for (int i = 0; i < W; i++) begin
            chk("valid", 72'(w.win_valid), 72'd1);
            chk("col", 72'(w.col), 72'(i));
            chk("last", 72'(w.last), 72'(i == W - 1));
            chk("r_win", w.R_win, ew(t, m, b, i));
            chk("g_win", w.G_win, ew(t + 64, m + 64, b + 64, i));
            chk("b_win", w.B_win, ew(t + 128, m + 128, b + 128, i));
            if (i == 0) chk("first_win", w.R_win, first);
            tick;
        end
        chk("done_pulse", 72'(done), 72'd1);
        chk("valid_drop", 72'(w.win_valid), 72'd0);
        tick;
        chk("done_clear", 72'(done), 72'd0);
        chk("busy_clear", 72'(busy), 72'd0);
        load_rows(1'b0);
    endtask

    initial begin
        load_rows(1'b0);
        w.win_ready = 1'b1;
        tick;
        tick;
        chk("rst_valid", 72'(w.win_valid), 72'd0);
        chk("rst_col", 72'(w.col), 72'd0);
        chk("rst_last", 72'(w.last), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_rwin", w.R_win, 72'd0);
        reset = 1'b0;
        tick;

        top_row = 2'd0;
        pass(0, 16, 32, 1'b0, FIRST_T0);

        top_row = 2'd1;
        pass(16, 32, 0, 1'b1, FIRST_T1);

        // Backpressure at col 1 with top_row 3 (behaves as 0), plus start while busy and in DONE.
        top_row = 2'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("t3_first", w.R_win, FIRST_T0);
        tick;
        w.win_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_col", 72'(w.col), 72'd1);
            chk("stall_valid", 72'(w.win_valid), 72'd1);
            chk("stall_last", 72'(w.last), 72'd0);
            chk("stall_rwin", w.R_win, ew(0, 16, 32, 1));
        end
        w.win_ready = 1'b1;
        tick;
        chk("after_stall_col", 72'(w.col), 72'd2);
        start = 1'b1;
        tick;
        chk("busy_start_col", 72'(w.col), 72'd3);
        chk("busy_start_last", 72'(w.last), 72'd1);
        tick;
        chk("bp_done", 72'(done), 72'd1);
        tick;
        start = 1'b0;
        chk("bp_done_once", 72'(done), 72'd0);
        chk("bp_idle", 72'(busy), 72'd0);
        tick;
        tick;
        chk("no_second_pass", 72'(busy), 72'd0);
        chk("no_second_valid", 72'(w.win_valid), 72'd0);
        chk("no_extra_done", 72'(done), 72'd0);
`ifdef PADDING_WINDOW_STALL_CNT_EN
        chk("stall_cnt", 72'(stall_cnt), 72'd3);
`endif

        // Reset in the middle of a pass.
        top_row = 2'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        chk("pre_rst_col", 72'(w.col), 72'd2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_valid", 72'(w.win_valid), 72'd0);
        chk("mid_rst_col", 72'(w.col), 72'd0);
        chk("mid_rst_busy", 72'(busy), 72'd0);
        chk("mid_rst_done", 72'(done), 72'd0);
        chk("mid_rst_rwin", w.R_win, 72'd0);
`ifdef PADDING_WINDOW_STALL_CNT_EN
        chk("mid_rst_stall", 72'(stall_cnt), 72'd0);
`endif
        tick;
        chk("mid_rst_no_done", 72'(done), 72'd0);
        pass(0, 16, 32, 1'b0, FIRST_T0);

        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
